// File: rtl/btn_autorepeat.sv
// Hold-to-repeat step generator. A clean button level becomes one step pulse
// on press, then, after an initial delay, periodic step pulses while held.
// One instance per direction feeding the up/down inputs of the counter.
module btn_autorepeat #(
   parameter int DELAY_CYC = 25000000,
   parameter int RATE_CYC  = 5000000,
   parameter int CNT_W     = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   input  logic en,
   output logic step,
   output logic repeating
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_PRESS  = 2'd1;
   localparam logic [1:0] S_REPEAT = 2'd2;

   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYC - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_CYC - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             step_q, step_d;
   logic             rep_q, rep_d;
   logic             btn_q;
   logic             rise;
   logic             hold;

   // Rise is only seen against the previous sampled level; btn_q resets high
   // so a button held through reset must be released before it can fire.
   assign rise = btn_in & ~btn_q;
   // Staying in PRESS/REPEAT requires the button held and the block enabled;
   // a release or disable on the edge a pulse is due therefore wins.
   assign hold = btn_in & en;

   // Next-state, interval counter and step pulse decode.
   // cnt counts whole cycles since the last pulse, starting from 0, so the
   // next pulse lands exactly DELAY_CYC / RATE_CYC edges after the previous.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      step_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (rise && en) begin
               step_d  = 1'b1;
               state_d = S_PRESS;
            end
         end
         S_PRESS: begin
            if (!hold) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DELAY_LAST) begin
               step_d  = 1'b1;
               state_d = S_REPEAT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_REPEAT: begin
            if (!hold) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == RATE_LAST) begin
               step_d = 1'b1;
               cnt_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      rep_d = (state_d == S_REPEAT);
   end

   // State, counter and registered outputs; reset has priority over all.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         step_q  <= 1'b0;
         rep_q   <= 1'b0;
         btn_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         rep_q   <= rep_d;
         btn_q   <= btn_in;
      end
   end

   assign step      = step_q;
   assign repeating = rep_q;

endmodule

// File: tb/tb_btn_autorepeat.sv
// Directed bench for btn_autorepeat with DELAY_CYC=8, RATE_CYC=4.
// Each vector drives inputs for one edge; outputs are checked just after it.
module tb_btn_autorepeat;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btn_in = 1'b0;
   logic en = 1'b1;
   logic step;
   logic repeating;

   int n_vec = 0;
   int n_bad = 0;

   btn_autorepeat #(.DELAY_CYC(8), .RATE_CYC(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in), .en(en),
      .step(step), .repeating(repeating)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst;
      logic btn;
      logic en;
      logic exp_step;
      logic exp_rep;
   } vec_t;

   vec_t tbl[35];

   // Drive one edge's inputs, then compare registered outputs after the edge.
   task automatic apply(input logic r, input logic b, input logic e,
                        input logic xs, input logic xr,
                        input string nm, input int edge_no);
      @(negedge clk);
      reset = r; btn_in = b; en = e;
      @(posedge clk);
      #1;
      n_vec++;
      if (step !== xs || repeating !== xr) begin
         n_bad++;
         $display("FAIL %s edge %0d: got step=%b repeating=%b, want step=%b repeating=%b",
                  nm, edge_no, step, repeating, xs, xr);
      end
   endtask

   initial begin
      // Test 1: press at edge 10, released (sampled low) at edge 30.
      // Pulses 10, 18, 22, 26; the due pulse at 30 is lost to the release.
      for (int e = 0; e < 35; e++) begin
         tbl[e].rst      = (e < 2);
         tbl[e].btn      = (e >= 10 && e < 30);
         tbl[e].en       = 1'b1;
         tbl[e].exp_step = (e == 10 || e == 18 || e == 22 || e == 26);
         tbl[e].exp_rep  = (e >= 18 && e <= 29);
      end
      for (int e = 0; e < 35; e++)
         apply(tbl[e].rst, tbl[e].btn, tbl[e].en, tbl[e].exp_step,
               tbl[e].exp_rep, "long_hold", e);

      // Test 2: short press, edges 10..14 high.
      for (int e = 0; e < 18; e++)
         apply(e < 2, e >= 10 && e <= 14, 1'b1, e == 10, 1'b0, "short_press", e);

      // Test 3: release sampled at edge 18, the edge the first repeat is due.
      for (int e = 0; e < 23; e++)
         apply(e < 2, e >= 10 && e <= 17, 1'b1, e == 10, 1'b0, "release_vs_due", e);

      // Test 4: en low 20..24 while held, back high at 25 with button still held;
      // no step until release at 35 and a fresh rise at 38.
      for (int e = 0; e < 41; e++)
         apply(e < 2, (e >= 10 && e < 35) || e >= 38, !(e >= 20 && e <= 24),
               e == 10 || e == 18 || e == 38, e == 18 || e == 19, "en_drop", e);

      // Test 5: button held through reset never fires; press at 40 does.
      for (int e = 0; e < 43; e++)
         apply(e < 2, e < 35 || e >= 40, 1'b1, e == 40, 1'b0, "held_thru_reset", e);

      // Test 6: reset at edge 21 mid-REPEAT; no pulse at 22 and no refire
      // afterwards since the button is still held.
      for (int e = 0; e < 27; e++)
         apply(e < 2 || e == 21, e >= 10 && e <= 26, 1'b1,
               e == 10 || e == 18, e >= 18 && e <= 20, "reset_mid_repeat", e);

      // Same-edge disable against a due repeat pulse (edge 22) in REPEAT.
      for (int e = 0; e < 25; e++)
         apply(e < 2, e >= 10, e != 22 && e < 23,
               e == 10 || e == 18, e >= 18 && e <= 21, "disable_vs_due", e);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, want completion");
      $fatal(1);
   end

endmodule
